// File: rtl/riscv_fetch_pkg.sv
// Shared types for the instruction fetch sequencer: FSM states, buffer entry
// layout and the default reset PC.
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_buf2.sv
// Two-entry FIFO holding {pc, instr} pairs between the instruction memory and
// decode. Flush beats push and pop; head outputs read zero when empty.
module fetch_buf2
  import riscv_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_instr,
  input  logic        pop,
  input  logic        flush,
  output logic        head_valid,
  output logic [31:0] head_pc,
  output logic [31:0] head_instr,
  output logic [1:0]  occ
);

  fetch_entry_t slots [2];
  fetch_entry_t head;
  logic         rd_ptr;
  logic         wr_ptr;

  // A push while full is legal only alongside a pop; it overwrites the slot
  // being popped, whose contents were already presented this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slots[0] <= '0;
      slots[1] <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      occ      <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        slots[wr_ptr] <= '{pc: push_pc, instr: push_instr};
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + 2'(push) - 2'(pop);
    end
  end

  assign head_valid = (occ != 2'd0);
  assign head       = head_valid ? slots[rd_ptr] : '0;
  assign head_pc    = head.pc;
  assign head_instr = head.instr;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one read per cycle to a 1-cycle
// synchronous instruction memory, and hands {pc, instr} to decode.
module instr_fetch_ctrl
  import riscv_fetch_pkg::*;
#(
  parameter int          MEM_DEPTH = 1024,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_fault
);

  localparam logic [32:0] PC_LIMIT = 33'(MEM_DEPTH) * 33'd4;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q;
  logic         epoch;
  logic         inflight;
  logic [31:0]  inflight_pc;
  logic         inflight_epoch;
  logic         fault_d;
  logic [1:0]   occ;
  logic [2:0]   credit_sum;
  logic         credit_ok;
  logic         bad_pc;
  logic         pop;
  logic         push;
  logic         issue;

  assign imem_addr  = pc_q;
  assign pop        = out_valid & out_ready;
  assign push       = inflight & (inflight_epoch == epoch);
  assign credit_sum = 3'(occ) + 3'(inflight) - 3'(pop);
  assign credit_ok  = (credit_sum < 3'd2);
  assign bad_pc     = (pc_q[1:0] != 2'b00) | ({1'b0, pc_q} >= PC_LIMIT);
  assign issue      = (state_q == RUN) & fetch_en & ~redirect_valid & credit_ok & ~bad_pc;

  // Redirect overrides everything; a fault only latches while actively running.
  always_comb begin
    state_d = state_q;
    fault_d = fetch_fault;
    unique case (state_q)
      IDLE: begin
        if (!redirect_valid && fetch_en) state_d = RUN;
      end
      RUN: begin
        if (redirect_valid) begin
          state_d = fetch_en ? RUN : IDLE;
        end else if (!fetch_en) begin
          state_d = IDLE;
        end else if (bad_pc) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end
      end
      FAULT: begin
        if (redirect_valid) begin
          state_d = fetch_en ? RUN : IDLE;
          fault_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      pc_q           <= RESET_PC;
      epoch          <= 1'b0;
      inflight       <= 1'b0;
      inflight_pc    <= '0;
      inflight_epoch <= 1'b0;
      fetch_fault    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_fault <= fault_d;
      inflight    <= issue;
      if (redirect_valid) begin
        pc_q  <= redirect_pc;
        epoch <= ~epoch;
      end else if (issue) begin
        pc_q           <= pc_q + 32'd4;
        inflight_pc    <= pc_q;
        inflight_epoch <= epoch;
      end
    end
  end

  fetch_buf2 u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_pc    (inflight_pc),
    .push_instr (imem_rdata),
    .pop        (pop),
    .flush      (redirect_valid),
    .head_valid (out_valid),
    .head_pc    (out_pc),
    .head_instr (out_instr),
    .occ        (occ)
  );

endmodule
